// File: rtl/proc_param.sv
// Parametrised multicycle processor: eight registers, an accumulator-style ALU path
// through A and G, a zero flag, and a Run/Done handshake on a shared internal bus.
module proc_param #(
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] DIN,
   input  logic              Run,
   output logic              Done,
   output logic [DATA_W-1:0] BusWires
);

   // state | meaning
   // IDLE  | waiting for Run; latches the instruction from DIN[8:0]
   // T1    | mv/mvi/mvnz complete here; ALU ops load A from Rx
   // T2    | ALU computes A op Ry into G and updates Z
   // T3    | G written back to Rx
   typedef enum logic [1:0] {IDLE = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} stateT;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_MVNZ = 3'b111;

   stateT             state, nextState;
   logic [8:0]        ir;
   logic [DATA_W-1:0] regs [8];
   logic [DATA_W-1:0] regA, regG;
   logic              zFlag;

   logic [2:0]        op, rx, ry;
   logic [7:0]        rIn;
   logic              aIn, gIn;
   logic [DATA_W-1:0] aluOut;

   assign op = ir[8:6];
   assign rx = ir[5:3];
   assign ry = ir[2:0];

   // In T2 the bus carries Ry, so the ALU's second operand is simply the bus.
   always_comb begin
      aluOut = '0;
      case (op)
         OP_ADD:  aluOut = regA + BusWires;
         OP_SUB:  aluOut = regA - BusWires;
         OP_AND:  aluOut = regA & BusWires;
         OP_OR:   aluOut = regA | BusWires;
         OP_XOR:  aluOut = regA ^ BusWires;
         default: aluOut = '0;
      endcase
   end

   always_comb begin
      nextState = state;
      BusWires  = '0;
      Done      = 1'b0;
      rIn       = '0;
      aIn       = 1'b0;
      gIn       = 1'b0;
      case (state)
         IDLE: begin
            if (Run) nextState = T1;
         end
         T1: begin
            case (op)
               OP_MV: begin
                  BusWires  = regs[ry];
                  rIn[rx]   = 1'b1;
                  Done      = 1'b1;
                  nextState = IDLE;
               end
               OP_MVI: begin
                  BusWires  = DIN;
                  rIn[rx]   = 1'b1;
                  Done      = 1'b1;
                  nextState = IDLE;
               end
               OP_MVNZ: begin
                  BusWires  = regs[ry];
                  rIn[rx]   = ~zFlag;
                  Done      = 1'b1;
                  nextState = IDLE;
               end
               default: begin
                  BusWires  = regs[rx];
                  aIn       = 1'b1;
                  nextState = T2;
               end
            endcase
         end
         T2: begin
            BusWires  = regs[ry];
            gIn       = 1'b1;
            nextState = T3;
         end
         T3: begin
            BusWires  = regG;
            rIn[rx]   = 1'b1;
            Done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Reset wins over every write enable, so an aborted instruction never commits.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
         ir    <= '0;
         regA  <= '0;
         regG  <= '0;
         zFlag <= 1'b1;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE && Run) ir <= DIN[8:0];
         if (aIn) regA <= BusWires;
         if (gIn) begin
            regG  <= aluOut;
            zFlag <= (aluOut == '0);
         end
         for (int i = 0; i < 8; i++) begin
            if (rIn[i]) regs[i] <= BusWires;
         end
      end
   end

endmodule

// File: tb/tb_proc_param.sv
// Bench for proc_param: an ISA-level register model predicts the per-cycle bus and
// Done values, which are queued and compared against what the DUT shows each cycle.
module tb_proc_param;

   localparam int DATA_W = 16;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_MVNZ = 3'b111;

   logic              Clock;
   logic              Reset;
   logic [DATA_W-1:0] DIN;
   logic              Run;
   logic              Done;
   logic [DATA_W-1:0] BusWires;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] mdlR [8];
   logic              mdlZ;

   logic [DATA_W-1:0] expBus[$];
   logic              expDone[$];
   logic [DATA_W-1:0] obsBus[$];
   logic              obsDone[$];
   logic              rec = 1'b0;

   proc_param #(.DATA_W(DATA_W)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .DIN      (DIN),
      .Run      (Run),
      .Done     (Done),
      .BusWires (BusWires)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always @(negedge Clock) begin
      if (rec) begin
         obsBus.push_back(BusWires);
         obsDone.push_back(Done);
      end
   end

   task automatic startRec();
      expBus.delete(); expDone.delete();
      obsBus.delete(); obsDone.delete();
      rec = 1'b1;
   endtask

   task automatic pushExp(input logic [DATA_W-1:0] b, input logic d);
      expBus.push_back(b);
      expDone.push_back(d);
   endtask

   // Entered at posedge+1 with the DUT in IDLE; leaves at posedge+1 back in IDLE.
   // runMid is the Run level in non-IDLE cycles; T2 drives its complement.
   task automatic issue(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                        input logic [DATA_W-1:0] imm, input logic runMid);
      logic [DATA_W-1:0] res;
      Run = 1'b1;
      DIN = {7'h5A, op, x, y};
      pushExp('0, 1'b0);
      @(posedge Clock); #1;
      Run = runMid;
      DIN = imm;
      case (op)
         OP_MV:   begin pushExp(mdlR[y], 1'b1); mdlR[x] = mdlR[y]; end
         OP_MVI:  begin pushExp(imm, 1'b1); mdlR[x] = imm; end
         OP_MVNZ: begin pushExp(mdlR[y], 1'b1); if (!mdlZ) mdlR[x] = mdlR[y]; end
         default: begin
            pushExp(mdlR[x], 1'b0);
            case (op)
               OP_ADD:  res = mdlR[x] + mdlR[y];
               OP_SUB:  res = mdlR[x] - mdlR[y];
               OP_AND:  res = mdlR[x] & mdlR[y];
               OP_OR:   res = mdlR[x] | mdlR[y];
               default: res = mdlR[x] ^ mdlR[y];
            endcase
            @(posedge Clock); #1;
            Run = ~runMid;
            DIN = $urandom_range(0, 65535);
            pushExp(mdlR[y], 1'b0);
            @(posedge Clock); #1;
            Run = runMid;
            pushExp(res, 1'b1);
            mdlR[x] = res;
            mdlZ = (res == '0);
         end
      endcase
      @(posedge Clock); #1;
      Run = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Run = 1'b1; DIN = {7'h00, OP_MVI, 3'd1, 3'd0};
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0; Run = 1'b0;
      for (int i = 0; i < 8; i++) mdlR[i] = '0;
      mdlZ = 1'b1;
      @(negedge Clock);
      checks++;
      if (Done !== 1'b0 || BusWires !== '0) begin
         errors++;
         $display("FAIL reset_outputs: Done=%b BusWires=%h, required Done=0 BusWires=0000", Done, BusWires);
      end
      @(posedge Clock); #1;
      startRec();
      for (int i = 0; i < 8; i++) issue(OP_MV, 3'd0, i[2:0], '0, 1'b0);
      issue(OP_MVI, 3'd1, 3'd0, 16'h0003, 1'b0);
      issue(OP_MVNZ, 3'd2, 3'd1, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd2, '0, 1'b0);
      rec = 1'b0;
      checks++;
      if (obsBus.size() != expBus.size()) begin
         errors++;
         $display("FAIL reset_len: got %0d cycles, required %0d", obsBus.size(), expBus.size());
      end
      for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
         checks++;
         if (obsBus[i] !== expBus[i] || obsDone[i] !== expDone[i]) begin
            errors++;
            $display("FAIL reset_cycle%0d: bus=%h done=%b, required bus=%h done=%b",
                     i, obsBus[i], obsDone[i], expBus[i], expDone[i]);
         end
      end
   endtask

   task automatic test_mv_mvi();
      startRec();
      issue(OP_MVI, 3'd1, 3'd0, 16'h1234, 1'b0);
      issue(OP_MV, 3'd2, 3'd1, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd2, '0, 1'b0);
      rec = 1'b0;
      checks++;
      if (obsBus.size() != expBus.size()) begin
         errors++;
         $display("FAIL mv_len: got %0d cycles, required %0d", obsBus.size(), expBus.size());
      end
      for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
         checks++;
         if (obsBus[i] !== expBus[i] || obsDone[i] !== expDone[i]) begin
            errors++;
            $display("FAIL mv_cycle%0d: bus=%h done=%b, required bus=%h done=%b",
                     i, obsBus[i], obsDone[i], expBus[i], expDone[i]);
         end
      end
      if (obsBus.size() > 5) begin
         checks++;
         if (obsBus[3] !== 16'h1234 || obsBus[5] !== 16'h1234) begin
            errors++;
            $display("FAIL mv_value: mv T1 bus=%h readback=%h, required 1234", obsBus[3], obsBus[5]);
         end
      end
   endtask

   task automatic test_add();
      startRec();
      issue(OP_MVI, 3'd1, 3'd0, 16'h0005, 1'b0);
      issue(OP_MVI, 3'd2, 3'd0, 16'h0007, 1'b0);
      issue(OP_ADD, 3'd1, 3'd2, '0, 1'b0);
      issue(OP_MVI, 3'd5, 3'd0, 16'h0000, 1'b0);
      issue(OP_MVNZ, 3'd5, 3'd1, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd5, '0, 1'b0);
      rec = 1'b0;
      checks++;
      if (obsBus.size() != expBus.size()) begin
         errors++;
         $display("FAIL add_len: got %0d cycles, required %0d", obsBus.size(), expBus.size());
      end
      for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
         checks++;
         if (obsBus[i] !== expBus[i] || obsDone[i] !== expDone[i]) begin
            errors++;
            $display("FAIL add_cycle%0d: bus=%h done=%b, required bus=%h done=%b",
                     i, obsBus[i], obsDone[i], expBus[i], expDone[i]);
         end
      end
      if (obsBus.size() > 7) begin
         checks++;
         if (obsBus[5] !== 16'h0005 || obsBus[6] !== 16'h0007 || obsBus[7] !== 16'h000C ||
             obsDone[5] !== 1'b0 || obsDone[6] !== 1'b0 || obsDone[7] !== 1'b1) begin
            errors++;
            $display("FAIL add_seq: bus %h %h %h done %b%b%b, required 0005 0007 000c done 001",
                     obsBus[5], obsBus[6], obsBus[7], obsDone[5], obsDone[6], obsDone[7]);
         end
      end
   endtask

   task automatic test_sub_mvnz();
      startRec();
      issue(OP_MVI, 3'd3, 3'd0, 16'h0000, 1'b0);
      issue(OP_MVI, 3'd4, 3'd0, 16'h0001, 1'b0);
      issue(OP_SUB, 3'd3, 3'd4, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd3, '0, 1'b0);
      issue(OP_SUB, 3'd3, 3'd3, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd3, '0, 1'b0);
      issue(OP_MVI, 3'd5, 3'd0, 16'h0000, 1'b0);
      issue(OP_MVNZ, 3'd5, 3'd4, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd5, '0, 1'b0);
      issue(OP_ADD, 3'd4, 3'd4, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd4, '0, 1'b0);
      rec = 1'b0;
      checks++;
      if (obsBus.size() != expBus.size()) begin
         errors++;
         $display("FAIL sub_len: got %0d cycles, required %0d", obsBus.size(), expBus.size());
      end
      for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
         checks++;
         if (obsBus[i] !== expBus[i] || obsDone[i] !== expDone[i]) begin
            errors++;
            $display("FAIL sub_cycle%0d: bus=%h done=%b, required bus=%h done=%b",
                     i, obsBus[i], obsDone[i], expBus[i], expDone[i]);
         end
      end
      if (obsBus.size() > 9) begin
         checks++;
         if (obsBus[9] !== 16'hFFFF) begin
            errors++;
            $display("FAIL sub_wrap: R3=%h, required ffff", obsBus[9]);
         end
      end
   endtask

   task automatic test_logic();
      logic [2:0]        ops  [3];
      logic [DATA_W-1:0] want [3];
      ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_XOR;
      want[0] = 16'h000F; want[1] = 16'h0FFF; want[2] = 16'h0FF0;
      for (int k = 0; k < 3; k++) begin
         startRec();
         issue(OP_MVI, 3'd6, 3'd0, 16'h0F0F, 1'b0);
         issue(OP_MVI, 3'd7, 3'd0, 16'h00FF, 1'b0);
         issue(ops[k], 3'd6, 3'd7, '0, 1'b0);
         issue(OP_MV, 3'd0, 3'd6, '0, 1'b0);
         rec = 1'b0;
         checks++;
         if (obsBus.size() != expBus.size()) begin
            errors++;
            $display("FAIL logic%0d_len: got %0d cycles, required %0d", k, obsBus.size(), expBus.size());
         end
         for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
            checks++;
            if (obsBus[i] !== expBus[i] || obsDone[i] !== expDone[i]) begin
               errors++;
               $display("FAIL logic%0d_cycle%0d: bus=%h done=%b, required bus=%h done=%b",
                        k, i, obsBus[i], obsDone[i], expBus[i], expDone[i]);
            end
         end
         if (obsBus.size() > 0) begin
            checks++;
            if (obsBus[obsBus.size()-1] !== want[k]) begin
               errors++;
               $display("FAIL logic%0d_value: R6=%h, required %h", k, obsBus[obsBus.size()-1], want[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int nDone;
      startRec();
      for (int i = 0; i < 4; i++)
         issue(OP_MVI, i[2:0], 3'd0, 16'hA000 + 16'(i), 1'b1);
      issue(OP_ADD, 3'd1, 3'd2, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd1, '0, 1'b0);
      rec = 1'b0;
      checks++;
      if (obsBus.size() != expBus.size()) begin
         errors++;
         $display("FAIL b2b_len: got %0d cycles, required %0d", obsBus.size(), expBus.size());
      end
      for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
         checks++;
         if (obsBus[i] !== expBus[i] || obsDone[i] !== expDone[i]) begin
            errors++;
            $display("FAIL b2b_cycle%0d: bus=%h done=%b, required bus=%h done=%b",
                     i, obsBus[i], obsDone[i], expBus[i], expDone[i]);
         end
      end
      nDone = 0;
      for (int i = 0; i < 8 && i < obsDone.size(); i++) if (obsDone[i] === 1'b1) nDone++;
      checks++;
      if (nDone != 4) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d pulses, required 4", nDone);
      end
   endtask

   task automatic test_reset_abort();
      startRec();
      issue(OP_MVI, 3'd1, 3'd0, 16'h0005, 1'b0);
      issue(OP_MVI, 3'd2, 3'd0, 16'h0007, 1'b0);
      rec = 1'b0;
      Run = 1'b1;
      DIN = {7'h00, OP_ADD, 3'd1, 3'd2};
      @(posedge Clock); #1;
      Run = 1'b0;
      @(posedge Clock); #1;
      Reset = 1'b1;
      Run = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      Run = 1'b0;
      for (int i = 0; i < 8; i++) mdlR[i] = '0;
      mdlZ = 1'b1;
      @(negedge Clock);
      checks++;
      if (Done !== 1'b0 || BusWires !== '0) begin
         errors++;
         $display("FAIL abort_outputs: Done=%b BusWires=%h, required Done=0 BusWires=0000", Done, BusWires);
      end
      @(posedge Clock); #1;
      startRec();
      issue(OP_MV, 3'd3, 3'd1, '0, 1'b0);
      issue(OP_MVI, 3'd5, 3'd0, 16'h0009, 1'b0);
      issue(OP_MVNZ, 3'd2, 3'd5, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd2, '0, 1'b0);
      issue(OP_ADD, 3'd5, 3'd5, '0, 1'b0);
      issue(OP_MV, 3'd0, 3'd5, '0, 1'b0);
      rec = 1'b0;
      checks++;
      if (obsBus.size() != expBus.size()) begin
         errors++;
         $display("FAIL abort_len: got %0d cycles, required %0d", obsBus.size(), expBus.size());
      end
      for (int i = 0; i < expBus.size() && i < obsBus.size(); i++) begin
         checks++;
         if (obsBus[i] !== expBus[i] || obsDone[i] !== expDone[i]) begin
            errors++;
            $display("FAIL abort_cycle%0d: bus=%h done=%b, required bus=%h done=%b",
                     i, obsBus[i], obsDone[i], expBus[i], expDone[i]);
         end
      end
      if (obsBus.size() > 0) begin
         checks++;
         if (obsBus[obsBus.size()-1] !== 16'h0012) begin
            errors++;
            $display("FAIL abort_resume: R5=%h, required 0012", obsBus[obsBus.size()-1]);
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      Run   = 1'b0;
      DIN   = '0;
      test_reset();
      test_mv_mvi();
      test_add();
      test_sub_mvnz();
      test_logic();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
